wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 7 +
 rtl/wb_mux.sv | 23 ++
 rtl/wb_regfile.sv | 74 +++++++
 tb/tb_wb_regfile.sv | 136 +++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared core constants for the writeback / register file slice.
package wb_regfile_pkg;
  localparam int          XLEN   = 32;
  localparam int          NREG   = 32;
  localparam int          RIDX_W = 5;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/wb_mux.sv
// Writeback data select: jump link address beats load data beats ALU result.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic              i_jmp,
  input  logic              i_mem_to_reg,
  input  logic [XLEN_P-1:0] i_alu,
  input  logic [XLEN_P-1:0] i_mem,
  input  logic [XLEN_P-1:0] i_pc,
  output logic [XLEN_P-1:0] o_data
);
  // Addition is truncated to XLEN_P, so pc+4 wraps naturally.
  logic [XLEN_P-1:0] w_link;
  assign w_link = i_pc + XLEN_P'(PC_INC);

  always_comb begin
    o_data = i_alu;
    if (i_jmp)             o_data = w_link;
    else if (i_mem_to_reg) o_data = i_mem;
  end
endmodule

// File: rtl/wb_regfile.sv
// Register file with writeback mux, write-first bypass and a commit counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREG_P = NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoReg_in,
  input  logic              jmp_in,
  input  logic              regWE_in,
  input  logic [4:0]        rd_in,
  input  logic [XLEN_P-1:0] alu_result_in,
  input  logic [XLEN_P-1:0] read_mem_data_in,
  input  logic [XLEN_P-1:0] pc_in,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [XLEN_P-1:0] rs1_data,
  output logic [XLEN_P-1:0] rs2_data,
  output logic [XLEN_P-1:0] wb_data_out,
  output logic              wb_we_out,
  output logic [31:0]       wr_count
);
  localparam logic [5:0] NREG6 = 6'(NREG_P);

  logic [XLEN_P-1:0] r_regs [1:NREG_P-1];
  logic [31:0]       r_wr_count;
  logic [XLEN_P-1:0] w_wb_data;
  logic              w_we;

  wb_mux #(.XLEN_P(XLEN_P)) u_wb_mux (
    .i_jmp        (jmp_in),
    .i_mem_to_reg (MemtoReg_in),
    .i_alu        (alu_result_in),
    .i_mem        (read_mem_data_in),
    .i_pc         (pc_in),
    .o_data       (w_wb_data)
  );

  assign w_we        = regWE_in & (rd_in != 5'd0) & ~rst;
  assign wb_we_out   = w_we;
  assign wb_data_out = w_wb_data;
  assign wr_count    = r_wr_count;

  // Indices at or beyond NREG_P match no slot, so such writes drop silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG_P; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else begin
      for (int i = 1; i < NREG_P; i++)
        if (w_we && rd_in == 5'(i)) r_regs[i] <= w_wb_data;
      if (w_we) r_wr_count <= r_wr_count + 32'd1;
    end
  end

  function automatic logic [XLEN_P-1:0] rd_port(input logic [4:0] addr);
    logic [XLEN_P-1:0] v;
    v = '0;
    if (!rst && addr != 5'd0 && {1'b0, addr} < NREG6) begin
      if (w_we && addr == rd_in) v = w_wb_data;
      else
        for (int i = 1; i < NREG_P; i++)
          if (addr == 5'(i)) v = r_regs[i];
    end
    return v;
  endfunction

  always_comb begin
    rs1_data = rd_port(rs1_addr);
    rs2_data = rd_port(rs2_addr);
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst, MemtoReg_in, jmp_in, regWE_in;
  logic [4:0]  rd_in, rs1_addr, rs2_addr;
  logic [31:0] alu_result_in, read_mem_data_in, pc_in;
  logic [31:0] rs1_data, rs2_data, wb_data_out, wr_count;
  logic        wb_we_out;
  int          checks = 0;
  int          failures = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst), .MemtoReg_in(MemtoReg_in), .jmp_in(jmp_in),
    .regWE_in(regWE_in), .rd_in(rd_in), .alu_result_in(alu_result_in),
    .read_mem_data_in(read_mem_data_in), .pc_in(pc_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_data_out(wb_data_out), .wb_we_out(wb_we_out),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] alu);
    regWE_in = 1'b1; MemtoReg_in = 1'b0; jmp_in = 1'b0;
    rd_in = rd; alu_result_in = alu;
    tick();
    regWE_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; MemtoReg_in = 1'b0; jmp_in = 1'b0; regWE_in = 1'b1;
    rd_in = 5'd3; alu_result_in = 32'h1; read_mem_data_in = 32'h0;
    pc_in = 32'h0; rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    chk("rst_we_out", {31'b0, wb_we_out}, 32'h0);
    chk("rst_rs1", rs1_data, 32'h0);
    chk("rst_wbdata_comb", wb_data_out, 32'h1);
    tick(); tick();
    rst = 1'b0; regWE_in = 1'b0;
    #1;
    chk("reset_count", wr_count, 32'h0);
    chk("reset_x3", rs1_data, 32'h0);

    // basic ALU write
    regWE_in = 1'b1; rd_in = 5'd5; alu_result_in = 32'h1234; #1;
    chk("we_out_high", {31'b0, wb_we_out}, 32'h1);
    tick(); regWE_in = 1'b0; rs1_addr = 5'd5; #1;
    chk("x5_alu", rs1_data, 32'h1234);
    chk("count_1", wr_count, 32'h1);

    // load writeback with same-cycle bypass
    regWE_in = 1'b1; rd_in = 5'd7; MemtoReg_in = 1'b1;
    read_mem_data_in = 32'hDEADBEEF; rs2_addr = 5'd7; rs1_addr = 5'd5; #1;
    chk("bypass_rs2", rs2_data, 32'hDEADBEEF);
    chk("no_bypass_rs1", rs1_data, 32'h1234);
    tick(); regWE_in = 1'b0; MemtoReg_in = 1'b0; rs1_addr = 5'd7; #1;
    chk("stored_rs2", rs2_data, 32'hDEADBEEF);
    chk("same_addr_rs1", rs1_data, 32'hDEADBEEF);
    chk("count_2", wr_count, 32'h2);

    // jump link wraps to zero
    wr(5'd1, 32'h55);
    regWE_in = 1'b1; rd_in = 5'd1; jmp_in = 1'b1; MemtoReg_in = 1'b1;
    pc_in = 32'hFFFFFFFC; rs1_addr = 5'd1; #1;
    chk("jmp_wrap_wbdata", wb_data_out, 32'h0);
    tick(); regWE_in = 1'b0; #1;
    chk("x1_zero", rs1_data, 32'h0);
    chk("count_4", wr_count, 32'h4);
    pc_in = 32'h100; #1;
    chk("jmp_link", wb_data_out, 32'h104);
    jmp_in = 1'b0; #1;
    chk("mem_sel", wb_data_out, 32'hDEADBEEF);
    MemtoReg_in = 1'b0; alu_result_in = 32'h77; #1;
    chk("alu_sel", wb_data_out, 32'h77);

    // x0 write is dropped
    regWE_in = 1'b1; rd_in = 5'd0; alu_result_in = 32'hFFFF; rs1_addr = 5'd0; #1;
    chk("x0_read", rs1_data, 32'h0);
    chk("x0_we_out", {31'b0, wb_we_out}, 32'h0);
    tick(); regWE_in = 1'b0; #1;
    chk("x0_count", wr_count, 32'h4);
    chk("x0_after", rs1_data, 32'h0);

    // disabled write leaves state
    regWE_in = 1'b0; rd_in = 5'd5; alu_result_in = 32'h9999; tick();
    rs1_addr = 5'd5; #1;
    chk("nowe_x5", rs1_data, 32'h1234);
    chk("nowe_count", wr_count, 32'h4);

    // reset beats a concurrent write
    wr(5'd3, 32'hA5A5);
    rs1_addr = 5'd3; #1;
    chk("x3_a5", rs1_data, 32'hA5A5);
    rst = 1'b1; regWE_in = 1'b1; rd_in = 5'd3; alu_result_in = 32'h1; rs2_addr = 5'd3; #1;
    chk("rst_hi_rs1", rs1_data, 32'h0);
    chk("rst_hi_rs2", rs2_data, 32'h0);
    chk("rst_hi_we", {31'b0, wb_we_out}, 32'h0);
    tick();
    rst = 1'b0; rd_in = 5'd9; alu_result_in = 32'h77; rs2_addr = 5'd5; #1;
    chk("post_rst_x3", rs1_data, 32'h0);
    chk("post_rst_x5", rs2_data, 32'h0);
    chk("post_rst_count", wr_count, 32'h0);
    tick(); regWE_in = 1'b0; rs1_addr = 5'd9; #1;
    chk("first_write_x9", rs1_data, 32'h77);
    chk("first_write_count", wr_count, 32'h1);

    // counter wrap
    @(negedge clk);
    force dut.r_wr_count = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.r_wr_count;
    #1;
    chk("count_preload", wr_count, 32'hFFFFFFFF);
    @(negedge clk);
    regWE_in = 1'b1; rd_in = 5'd2; alu_result_in = 32'h2;
    @(posedge clk); #1; regWE_in = 1'b0; rs1_addr = 5'd2; #1;
    chk("count_wrap", wr_count, 32'h0);
    chk("wrap_x2", rs1_data, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
